datapath_sequencer: RTL

Hard-wired control unit that drives the Phase 1 Datapath through instruction fetch and execution of register-register ALU instructions. It replaces the bench-driven control strobes with a one-state-per-clock FSM. It decodes the IR contents returned from the datapath and handles the memory-read handshake. It produces one-hot register select strobes, and HI/LO writeback for mul/div.

---
 rtl/datapath_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/datapath_sequencer.sv
// Hard-wired fetch/execute sequencer for the phase 1 datapath.
// Ports: clk, clr (async reset), run, ir, mem_ready in; datapath strobes, one-hot r_in/r_out, busy/instr_done/fault/state_dbg out.
module datapath_sequencer #(
  parameter int NUM_REGS    = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                run,
  input  logic [31:0]         ir,
  input  logic                mem_ready,
  output logic                pc_out,
  output logic                zlo_out,
  output logic                zhi_out,
  output logic                mdr_out,
  output logic                mar_enable,
  output logic                mdr_enable,
  output logic                ir_enable,
  output logic                y_enable,
  output logic                z_enable,
  output logic                pc_enable,
  output logic                lo_enable,
  output logic                hi_enable,
  output logic                read,
  output logic                pc_increment,
  output logic [4:0]          op_code,
  output logic [NUM_REGS-1:0] r_in,
  output logic [NUM_REGS-1:0] r_out,
  output logic                busy,
  output logic                instr_done,
  output logic                fault,
  output logic [3:0]          state_dbg
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_FAULT = 4'd8
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;

  logic [4:0]          w_op;
  logic                w_bin;
  logic                w_md;
  logic                w_un;
  logic [NUM_REGS-1:0] w_ra_oh;
  logic [NUM_REGS-1:0] w_rb_oh;
  logic [NUM_REGS-1:0] w_rc_oh;
  logic                w_unused;

  assign w_op    = ir[31:27];
  assign w_bin   = (w_op >= 5'd3) && (w_op <= 5'd11);
  assign w_md    = (w_op == 5'd15) || (w_op == 5'd16);
  assign w_un    = (w_op == 5'd17) || (w_op == 5'd18);
  assign w_ra_oh = NUM_REGS'(1) << ir[26:23];
  assign w_rb_oh = NUM_REGS'(1) << ir[22:19];
  assign w_rc_oh = NUM_REGS'(1) << ir[18:15];
  assign w_unused = ^ir[14:0];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      // Counter is zeroed on the way into T1, counts wait cycles there.
      if (r_state == S_T0)
        r_cnt <= '0;
      else if (r_state == S_T1 && !mem_ready)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next       = r_state;
    pc_out       = 1'b0;
    zlo_out      = 1'b0;
    zhi_out      = 1'b0;
    mdr_out      = 1'b0;
    mar_enable   = 1'b0;
    mdr_enable   = 1'b0;
    ir_enable    = 1'b0;
    y_enable     = 1'b0;
    z_enable     = 1'b0;
    pc_enable    = 1'b0;
    lo_enable    = 1'b0;
    hi_enable    = 1'b0;
    read         = 1'b0;
    pc_increment = 1'b0;
    op_code      = 5'd0;
    r_in         = '0;
    r_out        = '0;
    instr_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (run) w_next = S_T0;
      end
      S_T0: begin
        pc_out       = 1'b1;
        mar_enable   = 1'b1;
        pc_increment = 1'b1;
        w_next       = S_T1;
      end
      S_T1: begin
        read       = 1'b1;
        mdr_enable = 1'b1;
        if (mem_ready)
          w_next = S_T2;
        else if (r_cnt == CW'(MEM_TIMEOUT - 1))
          w_next = S_FAULT;
      end
      S_T2: begin
        mdr_out   = 1'b1;
        ir_enable = 1'b1;
        w_next    = S_T3;
      end
      S_T3: begin
        if (w_bin || w_un) begin
          r_out    = w_rb_oh;
          y_enable = 1'b1;
          w_next   = S_T4;
        end else if (w_md) begin
          r_out    = w_ra_oh;
          y_enable = 1'b1;
          w_next   = S_T4;
        end else begin
          w_next = S_FAULT;
        end
      end
      S_T4: begin
        z_enable = 1'b1;
        op_code  = w_op;
        r_out    = w_bin ? w_rc_oh : w_rb_oh;
        w_next   = S_T5;
      end
      S_T5: begin
        zlo_out = 1'b1;
        if (w_md) begin
          lo_enable = 1'b1;
          w_next    = S_T6;
        end else begin
          r_in       = w_ra_oh;
          instr_done = 1'b1;
          w_next     = run ? S_T0 : S_IDLE;
        end
      end
      S_T6: begin
        zhi_out    = 1'b1;
        hi_enable  = 1'b1;
        instr_done = 1'b1;
        w_next     = run ? S_T0 : S_IDLE;
      end
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy      = (r_state != S_IDLE) && (r_state != S_FAULT);
  assign fault     = (r_state == S_FAULT);
  assign state_dbg = r_state;

endmodule
